ttl_gate_array_filtered: RTL and testbench
==========================================

// Module: ttl_gate_array_filtered
// PURPOSE
//  Parametrised array of BLOCKS independent WIDTH_IN-input gates with a run-time
//  selectable function (Mode) and a registered, glitch-filtered output per channel.
//  Successor to the fixed-function 3-input NOR arrays. Used as a clocked gate bank
//  where noisy or asynchronous inputs must only reach Y once they have been stable.
// PARAMETERS
//  BLOCKS        3  number of gate channels
//  WIDTH_IN      3  inputs per gate, >= 1
//  FILTER_CYCLES 2  consecutive sampled cycles a new result must persist before Y takes it, >= 1
//  DELAY_RISE    0  output rise delay applied to Y and Changed
//  DELAY_FALL    0  output fall delay applied to Y and Changed
// PORTS
//  Clk        input   1                 rising-edge clock; the block has no other clock
//  Clear_bar  input   1                 reset: synchronous, active-low
//  Enable     input   1                 1 = sample and filter; 0 = freeze all state
//  Mode       input   3                 gate function select, shared by all channels
//  A_2D       input   BLOCKS*WIDTH_IN   packed inputs; channel i = A_2D[i*WIDTH_IN +: WIDTH_IN]
//  Y          output  BLOCKS            filtered, registered gate outputs
//  Changed    output  BLOCKS            1-cycle pulse on the cycle after Y[i] toggles
// BEHAVIOUR
//  - Mode encoding:
//      000 AND; 001 NAND; 010 OR; 011 NOR; 100 XOR (odd parity); 101 XNOR
//      11x NOR (7427-compatible default)
//  - comp[i] = f_Mode(A[i]) is combinational. Only Y and Changed are visible outputs.
//  - Per-channel state:
//      Y_q[i]  held output
//      cnt[i]  width $clog2(FILTER_CYCLES+1), saturating
//  - Block state: Mode_q, the registered copy of Mode.
//  - Reset (Clear_bar == 0 at a Clk edge):
//      Y = 0, Changed = 0, all cnt = 0, Mode_q <= Mode
//      Overrides Enable and any in-progress count. Applies mid-filter: a partial count is discarded.
//  - Enable == 0: Y, cnt and Mode_q hold; Changed = 0.
//  - Enable == 1, Mode != Mode_q:
//      Mode_q <= Mode; all cnt <= 0; Y holds; Changed = 0
//      Filtering restarts under the new function.
//  - Enable == 1, Mode == Mode_q, per channel:
//      comp == Y_q: cnt <= 0
//      comp != Y_q and cnt == FILTER_CYCLES-1: Y_q <= comp; cnt <= 0; Changed[i] <= 1 on the next cycle
//      comp != Y_q otherwise: cnt <= cnt + 1
//  - Latency: a result held stable from edge k onward appears on Y after edge k+FILTER_CYCLES-1.
//    FILTER_CYCLES = 1 gives a plain 1-cycle register.
//  - A pulse shorter than FILTER_CYCLES sampled cycles never reaches Y. Its count is cleared
//    as soon as comp matches Y_q again. Partial counts do not accumulate across separate pulses.
//  - Channels are fully independent. Several may toggle on the same edge, each with its own Changed bit.
//  - Changed[i] is 1 for exactly one cycle per toggle of Y[i]. It is never asserted
//    during reset, when Enable is low, or on a Mode-change cycle.
//  - Y and Changed are driven with #(DELAY_RISE, DELAY_FALL).
// STRUCTURE
//  - Shared header: Mode encoding constants (MODE_AND .. MODE_XNOR) and the existing
//    ASSIGN_UNPACK_ARRAY macro used to unpack A_2D.
//  - One sub-module, ttl_gate_filter_cell:
//      one channel's cnt/Y_q/Changed logic
//      inputs: comp, Enable, Clear_bar, restart (the Mode-change strobe)
//  - Top level: unpacks A_2D, evaluates comp per Mode, registers Mode_q,
//    instantiates BLOCKS cells in a generate loop.
// TESTING (defaults BLOCKS=3, WIDTH_IN=3, FILTER_CYCLES=2 unless stated)
//  1. Reset, Mode=011, A_2D=0, Enable=1 -> Y=000 during reset; Y=111 after the 2nd edge
//     post-reset; Changed=111 for exactly one cycle.
//  2. Mode=011 steady, ch0 gets A=001 for 1 cycle then 000 -> Y[0] stays 1, Changed[0] stays 0.
//     The same input held 2 cycles -> Y[0]=0 after the 2nd edge.
//  3. Mode switched 011 -> 000 with A=111 on all channels -> no Y change on the switch edge;
//     Y=111 two edges later.
//  4. Enable=0 mid-count (cnt=1), inputs changed and held 5 cycles, then Enable=1 ->
//     Y frozen throughout, then updates one edge after re-enable.
//  5. Clear_bar pulsed low for 1 cycle while ch2 cnt=1 -> Y=000, Changed=000;
//     the next filter restarts from cnt=0.
//  6. FILTER_CYCLES=1, Mode=100, sweep all 8 values of A[1] -> Y[1] equals the parity of
//     A[1] one edge later. Also randomised comparison against a reference model for 1000 cycles.

Source files
------------

// File: rtl/ttl_gate_array_filtered_pkg.sv
// Shared gate-function encoding and the per-channel gate evaluation used by ttl_gate_array_filtered.
package ttl_gate_array_filtered_pkg;

    typedef enum logic [2:0] {
        MODE_AND   = 3'b000,
        MODE_NAND  = 3'b001,
        MODE_OR    = 3'b010,
        MODE_NOR   = 3'b011,
        MODE_XOR   = 3'b100,
        MODE_XNOR  = 3'b101,
        MODE_NOR_A = 3'b110,
        MODE_NOR_B = 3'b111
    } gate_mode_e;

    // Reductions are computed by the caller so the function stays independent of WIDTH_IN.
    function automatic logic gate_eval(gate_mode_e mode, logic all_ones, logic any_one,
                                       logic parity);
        logic res;
        case (mode)
            MODE_AND:  res = all_ones;
            MODE_NAND: res = ~all_ones;
            MODE_OR:   res = any_one;
            MODE_XOR:  res = parity;
            MODE_XNOR: res = ~parity;
            default:   res = ~any_one;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ttl_gate_array_filtered_filter_cell.sv
// One channel's glitch filter: a result must differ from Y for FILTER_CYCLES sampled cycles to be taken.
module ttl_gate_filter_cell #(
    parameter int FILTER_CYCLES = 2
) (
    input  logic Clk,
    input  logic Clear_bar,
    input  logic Enable,
    input  logic restart_i,
    input  logic comp_i,
    output logic y_o,
    output logic changed_o
);

    localparam int CNT_W = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             y_q, y_d;
    logic             changed_q, changed_d;

    always_comb begin
        // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latch).
        cnt_d     = cnt_q;
        y_d       = y_q;
        changed_d = 1'b0;
        if (Enable) begin
            if (restart_i) begin
                cnt_d = '0;
            end else if (comp_i == y_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                y_d       = comp_i;
                cnt_d     = '0;
                changed_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge Clk) begin
        if (!Clear_bar) begin
            cnt_q     <= '0;
            y_q       <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            y_q       <= y_d;
            changed_q <= changed_d;
        end
    end

    assign y_o       = y_q;
    assign changed_o = changed_q;

endmodule

// File: rtl/ttl_gate_array_filtered.sv
// Bank of BLOCKS run-time selectable WIDTH_IN-input gates with registered, glitch-filtered outputs.
module ttl_gate_array_filtered
    import ttl_gate_array_filtered_pkg::*;
#(
    parameter int BLOCKS        = 3,
    parameter int WIDTH_IN      = 3,
    parameter int FILTER_CYCLES = 2,
    parameter int DELAY_RISE    = 0,
    parameter int DELAY_FALL    = 0
) (
    input  logic                         Clk,
    input  logic                         Clear_bar,
    input  logic                         Enable,
    input  logic [2:0]                   Mode,
    input  logic [BLOCKS*WIDTH_IN-1:0]   A_2D,
    output logic [BLOCKS-1:0]            Y,
    output logic [BLOCKS-1:0]            Changed
);

    // Output delays are a simulation-model notion; this implementation is zero-delay.
    if (WIDTH_IN < 1 || FILTER_CYCLES < 1 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_params
        $error("ttl_gate_array_filtered: illegal parameter value");
    end

    gate_mode_e mode_q;
    logic       restart;

    always_ff @(posedge Clk) begin
        if (!Clear_bar || Enable) begin
            mode_q <= gate_mode_e'(Mode);
        end
    end

    assign restart = (Mode != mode_q);

    for (genvar i = 0; i < BLOCKS; i++) begin : g_ch
        logic [WIDTH_IN-1:0] a_ch;
        logic                comp;

        assign a_ch = A_2D[i*WIDTH_IN +: WIDTH_IN];
        assign comp = gate_eval(mode_q, &a_ch, |a_ch, ^a_ch);

        ttl_gate_filter_cell #(
            .FILTER_CYCLES (FILTER_CYCLES)
        ) u_cell (
            .Clk       (Clk),
            .Clear_bar (Clear_bar),
            .Enable    (Enable),
            .restart_i (restart),
            .comp_i    (comp),
            .y_o       (Y[i]),
            .changed_o (Changed[i])
        );
    end

endmodule

// File: tb/tb_ttl_gate_array_filtered.sv
// Directed and randomised checks of ttl_gate_array_filtered with FILTER_CYCLES=2 and =1 instances.
module tb_ttl_gate_array_filtered;

    logic       clk = 1'b0;
    logic       clear_bar;
    logic       enable;
    logic [2:0] mode;
    logic [8:0] a_2d;
    logic [2:0] y0, ch0, y1, ch1;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: index 0 = FILTER_CYCLES 2, index 1 = FILTER_CYCLES 1.
    logic [2:0] y_m    [2];
    logic [2:0] ch_m   [2];
    logic [2:0] mode_m [2];
    int         cnt_m  [2][3];

    always #5 clk = ~clk;

    ttl_gate_array_filtered dut0 (
        .Clk(clk), .Clear_bar(clear_bar), .Enable(enable), .Mode(mode),
        .A_2D(a_2d), .Y(y0), .Changed(ch0)
    );

    ttl_gate_array_filtered #(.FILTER_CYCLES(1)) dut1 (
        .Clk(clk), .Clear_bar(clear_bar), .Enable(enable), .Mode(mode),
        .A_2D(a_2d), .Y(y1), .Changed(ch1)
    );

    function automatic logic ref_comp(logic [2:0] m, logic [2:0] a);
        int ones = 0;
        for (int b = 0; b < 3; b++) ones += int'(a[b]);
        case (m)
            3'd0:    return ones == 3;
            3'd1:    return ones != 3;
            3'd2:    return ones != 0;
            3'd4:    return (ones % 2) == 1;
            3'd5:    return (ones % 2) == 0;
            default: return ones == 0;
        endcase
    endfunction

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int fc = (d == 0) ? 2 : 1;
            if (!clear_bar) begin
                y_m[d] = '0; ch_m[d] = '0; mode_m[d] = mode;
                for (int c = 0; c < 3; c++) cnt_m[d][c] = 0;
            end else if (!enable) begin
                ch_m[d] = '0;
            end else if (mode != mode_m[d]) begin
                mode_m[d] = mode; ch_m[d] = '0;
                for (int c = 0; c < 3; c++) cnt_m[d][c] = 0;
            end else begin
                for (int c = 0; c < 3; c++) begin
                    logic r;
                    r = ref_comp(mode_m[d], a_2d[c*3 +: 3]);
                    ch_m[d][c] = 1'b0;
                    if (r == y_m[d][c]) begin
                        cnt_m[d][c] = 0;
                    end else if (cnt_m[d][c] == fc - 1) begin
                        y_m[d][c] = r; cnt_m[d][c] = 0; ch_m[d][c] = 1'b1;
                    end else begin
                        cnt_m[d][c]++;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] par_tbl;
        par_tbl = 8'b1001_0110;

        // 1. Reset then NOR of all-zero inputs reaches Y on the 2nd edge.
        clear_bar = 1'b0; enable = 1'b1; mode = 3'b011; a_2d = '0;
        tick();
        check("rst_y", 32'(y0), 32'h0);
        check("rst_changed", 32'(ch0), 32'h0);
        check("rst_y_fc1", 32'(y1), 32'h0);
        clear_bar = 1'b1;
        tick();
        check("t1_edge1_y", 32'(y0), 32'h0);
        tick();
        check("t1_edge2_y", 32'(y0), 32'h7);
        check("t1_edge2_changed", 32'(ch0), 32'h7);
        tick();
        check("t1_changed_clear", 32'(ch0), 32'h0);

        // 2. One-cycle glitch on ch0 is rejected; a two-cycle one is accepted.
        a_2d = 9'b000_000_001;
        tick();
        check("t2_glitch_y", 32'(y0), 32'h7);
        a_2d = '0;
        tick();
        check("t2_after_glitch_y", 32'(y0), 32'h7);
        check("t2_after_glitch_changed", 32'(ch0), 32'h0);
        a_2d = 9'b000_000_001;
        tick();
        check("t2_hold1_y", 32'(y0), 32'h7);
        tick();
        check("t2_hold2_y", 32'(y0), 32'h6);
        check("t2_hold2_changed", 32'(ch0), 32'h1);
        tick();
        check("t2_changed_clear", 32'(ch0), 32'h0);

        // 3. Mode switch NOR -> AND: switch edge holds Y, filter restarts.
        mode = 3'b000; a_2d = 9'h1FF;
        tick();
        check("t3_switch_y", 32'(y0), 32'h6);
        check("t3_switch_changed", 32'(ch0), 32'h0);
        tick();
        check("t3_count_y", 32'(y0), 32'h6);
        tick();
        check("t3_done_y", 32'(y0), 32'h7);
        check("t3_done_changed", 32'(ch0), 32'h1);

        // 4. Freeze with ch1 mid-count, then resume.
        a_2d = 9'b111_000_111;
        tick();
        check("t4_midcount_y", 32'(y0), 32'h7);
        enable = 1'b0; a_2d = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t4_frozen_y", 32'(y0), 32'h7);
            check("t4_frozen_changed", 32'(ch0), 32'h0);
        end
        enable = 1'b1;
        tick();
        check("t4_resume_y", 32'(y0), 32'h5);
        check("t4_resume_changed", 32'(ch0), 32'h2);
        tick();
        check("t4_resume2_y", 32'(y0), 32'h0);
        check("t4_resume2_changed", 32'(ch0), 32'h5);

        // 5. Reset mid-filter discards the partial count on ch2.
        a_2d = 9'b111_000_000;
        tick();
        check("t5_midcount_y", 32'(y0), 32'h0);
        clear_bar = 1'b0;
        tick();
        check("t5_rst_y", 32'(y0), 32'h0);
        check("t5_rst_changed", 32'(ch0), 32'h0);
        clear_bar = 1'b1;
        tick();
        check("t5_restart_y", 32'(y0), 32'h0);
        tick();
        check("t5_done_y", 32'(y0), 32'h4);
        check("t5_done_changed", 32'(ch0), 32'h4);

        // 6. FILTER_CYCLES=1 instance: XOR parity sweep on channel 1.
        mode = 3'b100; a_2d = '0;
        tick();
        for (int v = 0; v < 8; v++) begin
            a_2d = 9'(v << 3);
            tick();
            check("t6_parity_y1", 32'(y1[1]), 32'(par_tbl[v]));
        end

        // Randomised run of both instances against the reference model.
        for (int k = 0; k < 1000; k++) begin
            if ($urandom_range(0, 2) == 0) a_2d = 9'($urandom);
            enable    = ($urandom_range(0, 9) != 0);
            clear_bar = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 19) == 0) mode = 3'($urandom_range(0, 7));
            tick();
            check("rand_y_fc2", 32'(y0), 32'(y_m[0]));
            check("rand_changed_fc2", 32'(ch0), 32'(ch_m[0]));
            check("rand_y_fc1", 32'(y1), 32'(y_m[1]));
            check("rand_changed_fc1", 32'(ch1), 32'(ch_m[1]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
